sccb_arbiter: RTL and testbench

//   Shares the single SCCB master between two register-write requesters: port 0 is the

---
 rtl/sccb_pkg.sv | 17 +
 rtl/arb_rr2.sv | 11 +
 rtl/sccb_arbiter.sv | 124 ++++++++++++
 tb/tb_sccb_arbiter.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sccb_pkg.sv
// sccb_pkg: shared FSM states, port ids and types for the SCCB write arbiter
package sccb_pkg;
    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;
    localparam logic [1:0] GAP       = 2'd3;

    localparam logic PORT_CFG = 1'b0;
    localparam logic PORT_RT  = 1'b1;

    localparam logic [7:0] OV7670_WR_ADDR = 8'h42;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;
endpackage

// File: rtl/arb_rr2.sv
// arb_rr2: two-way round-robin / fixed-priority picker, pointer held by the caller
module arb_rr2 (
    input  logic [1:0] valid,
    input  logic       ptr,
    input  logic       fixed_prio,
    output logic [1:0] grant,
    output logic       id
);
    assign id    = &valid ? (fixed_prio ? 1'b0 : ~ptr) : valid[1];
    assign grant = valid == 2'b00 ? 2'b00 : (id ? 2'b10 : 2'b01);
endmodule

// File: rtl/sccb_arbiter.sv
// sccb_arbiter: shares one SCCB master between the config sequencer and runtime control,
// with a per-phase watchdog and a forced idle gap between transactions
module sccb_arbiter
    import sccb_pkg::*;
#(
    parameter int clk_freq   = 25000000,
    parameter int TIMEOUT_US = 1000,
    parameter int GAP_CYCLES = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_addr,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    output logic       req0_done,
    output logic       req0_err,
    input  logic       req1_valid,
    input  logic [7:0] req1_addr,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       req1_done,
    output logic       req1_err,
    input  logic       sccb_ready,
    output logic       sccb_start,
    output logic [7:0] sccb_addr,
    output logic [7:0] sccb_reg,
    output logic       busy,
    output logic       grant_id,
    output logic       fault
);
    localparam int TO_CYC = clk_freq / 1000000 * TIMEOUT_US;
    localparam int WD_W   = $clog2(TO_CYC) + 1;
    localparam int GAP_W  = $clog2(GAP_CYCLES) + 1;
    localparam logic [WD_W-1:0]  WD_LOAD  = WD_W'(TO_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    logic [1:0]       state;
    logic [WD_W-1:0]  wd;
    logic [GAP_W-1:0] gap_cnt;
    logic             ptr;
    logic             pick_id;
    logic [1:0]       pick;
    wr_t              win;
    logic             timeout;
    logic             ack;
    logic             fin_ok;
    logic             fin_to;

    arb_rr2 u_pick (
        .valid      ({req1_valid, req0_valid}),
        .ptr        (ptr),
        .fixed_prio (FIXED_PRIO != 0),
        .grant      (pick),
        .id         (pick_id)
    );

    assign win     = pick[1] ? {req1_addr, req1_data} : {req0_addr, req0_data};
    assign busy    = state != IDLE;
    assign timeout = wd == '0;
    assign ack     = state == WAIT_ACK && !sccb_ready;
    assign fin_ok  = state == WAIT_DONE && sccb_ready;
    // the watchdog only fires if the phase's own completion did not arrive this cycle
    assign fin_to  = timeout && ((state == WAIT_ACK && sccb_ready) || (state == WAIT_DONE && !sccb_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wd         <= '0;
            gap_cnt    <= '0;
            ptr        <= PORT_RT;
            grant_id   <= PORT_CFG;
            sccb_start <= 1'b0;
            sccb_addr  <= '0;
            sccb_reg   <= '0;
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            req0_ready <= 1'b0;
            req1_ready <= 1'b0;
            req0_done  <= 1'b0;
            req1_done  <= 1'b0;
            req0_err   <= 1'b0;
            req1_err   <= 1'b0;
            if (state == IDLE && sccb_ready && |pick) begin
                sccb_addr  <= win.addr;
                sccb_reg   <= win.data;
                req0_ready <= pick[0];
                req1_ready <= pick[1];
                sccb_start <= 1'b1;
                grant_id   <= pick_id;
                ptr        <= pick_id;
                wd         <= WD_LOAD;
                state      <= WAIT_ACK;
            end else if (ack) begin
                sccb_start <= 1'b0;
                wd         <= WD_LOAD;
                state      <= WAIT_DONE;
            end else if (fin_ok || fin_to) begin
                sccb_start <= 1'b0;
                req0_done  <= grant_id == PORT_CFG;
                req1_done  <= grant_id == PORT_RT;
                req0_err   <= fin_to && grant_id == PORT_CFG;
                req1_err   <= fin_to && grant_id == PORT_RT;
                fault      <= fault | fin_to;
                gap_cnt    <= GAP_LOAD;
                state      <= GAP;
            end else if (state == GAP) begin
                if (gap_cnt == '0)
                    state <= IDLE;
                else
                    gap_cnt <= gap_cnt - 1'b1;
            end else if (!timeout) begin
                wd <= wd - 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_sccb_arbiter.sv
// tb_sccb_arbiter: directed vectors for the SCCB arbiter, round-robin and fixed-priority builds
module tb_sccb_arbiter;
    localparam int M_NORM  = 0;
    localparam int M_HUNG  = 1;
    localparam int M_STUCK = 2;

    typedef struct {
        logic [1:0] v;
        logic [7:0] a0, d0, a1, d1;
        logic       g;
        logic [7:0] ea, er;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] valid = 2'b00;
    logic [7:0] a0 = '0, d0 = '0, a1 = '0, d1 = '0;
    logic [1:0] rdy0, rdy1, done0, done1, err0, err1, start, busy, gid, fault;
    logic [7:0] saddr [2];
    logic [7:0] sreg [2];
    logic [1:0] m_rdy;
    int         m_cnt [2];
    int         mode = M_NORM;
    int         n_chk = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    sccb_arbiter #(.clk_freq(1000000), .TIMEOUT_US(50), .GAP_CYCLES(4), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst),
        .req0_valid(valid[0]), .req0_addr(a0), .req0_data(d0),
        .req0_ready(rdy0[0]), .req0_done(done0[0]), .req0_err(err0[0]),
        .req1_valid(valid[1]), .req1_addr(a1), .req1_data(d1),
        .req1_ready(rdy1[0]), .req1_done(done1[0]), .req1_err(err1[0]),
        .sccb_ready(m_rdy[0]), .sccb_start(start[0]), .sccb_addr(saddr[0]), .sccb_reg(sreg[0]),
        .busy(busy[0]), .grant_id(gid[0]), .fault(fault[0])
    );

    sccb_arbiter #(.clk_freq(1000000), .TIMEOUT_US(50), .GAP_CYCLES(4), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(valid[0]), .req0_addr(a0), .req0_data(d0),
        .req0_ready(rdy0[1]), .req0_done(done0[1]), .req0_err(err0[1]),
        .req1_valid(valid[1]), .req1_addr(a1), .req1_data(d1),
        .req1_ready(rdy1[1]), .req1_done(done1[1]), .req1_err(err1[1]),
        .sccb_ready(m_rdy[1]), .sccb_start(start[1]), .sccb_addr(saddr[1]), .sccb_reg(sreg[1]),
        .busy(busy[1]), .grant_id(gid[1]), .fault(fault[1])
    );

    // master model: ready drops 2 clk after start is first seen high, returns 20 clk later
    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || mode == M_HUNG) begin
                m_rdy[i] <= 1'b1;
                m_cnt[i] <= 0;
            end else if (m_cnt[i] != 0) begin
                m_cnt[i] <= m_cnt[i] + 1;
                if (m_cnt[i] == 1) m_rdy[i] <= 1'b0;
                if (m_cnt[i] >= 21 && mode == M_NORM) begin
                    m_rdy[i] <= 1'b1;
                    m_cnt[i] <= 0;
                end
            end else if (start[i]) begin
                m_cnt[i] <= 1;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle;
        int n;
        n = 0;
        while ((busy[0] || !m_rdy[0]) && n < 200) begin
            tick;
            n++;
        end
        chk("idle_bound", n < 200, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    initial begin
        vec_t       tbl [8];
        int         n;
        int         g_cnt;
        int         last_done;
        int         fp0;
        int         fp1;
        logic [3:0] seq;

        tbl[0] = '{2'b01, 8'h12, 8'h80, 8'h00, 8'h00, 1'b0, 8'h12, 8'h80};
        tbl[1] = '{2'b10, 8'h00, 8'h00, 8'h3A, 8'h04, 1'b1, 8'h3A, 8'h04};
        tbl[2] = '{2'b11, 8'h11, 8'h01, 8'h3A, 8'h04, 1'b0, 8'h11, 8'h01};
        tbl[3] = '{2'b11, 8'h11, 8'h01, 8'h3A, 8'h04, 1'b1, 8'h3A, 8'h04};
        tbl[4] = '{2'b11, 8'h11, 8'h01, 8'h3A, 8'h04, 1'b0, 8'h11, 8'h01};
        tbl[5] = '{2'b10, 8'h00, 8'h00, 8'h55, 8'hAA, 1'b1, 8'h55, 8'hAA};
        tbl[6] = '{2'b10, 8'h00, 8'h00, 8'h00, 8'hFF, 1'b1, 8'h00, 8'hFF};
        tbl[7] = '{2'b01, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00};

        #1;
        chk("rst_ctrl", {rdy0, rdy1, done0, done1, err0, err1, start, busy, gid, fault}, 0);
        chk("rst_data", {saddr[0], sreg[0], saddr[1], sreg[1]}, 0);
        repeat (2) tick;
        rst = 1'b0;
        tick;

        for (int i = 0; i < 8; i++) begin
            valid = tbl[i].v;
            a0 = tbl[i].a0; d0 = tbl[i].d0; a1 = tbl[i].a1; d1 = tbl[i].d1;
            tick;
            chk("vec_ready", {rdy1[0], rdy0[0]}, tbl[i].g ? 2'b10 : 2'b01);
            chk("vec_start", start[0], 1);
            chk("vec_addr", saddr[0], tbl[i].ea);
            chk("vec_reg", sreg[0], tbl[i].er);
            chk("vec_gid", gid[0], tbl[i].g);
            valid = 2'b00;
            a0 = 8'hE7; d0 = 8'h5C; a1 = 8'h9B; d1 = 8'h36;
            n = 0;
            do begin
                tick;
                n++;
            end while (!(done0[0] | done1[0]) && n < 100);
            chk("vec_done_lat", n, 23);
            chk("vec_done_port", {done1[0], done0[0]}, tbl[i].g ? 2'b10 : 2'b01);
            chk("vec_err", {err1[0], err0[0]}, 0);
            chk("vec_hold", {saddr[0], sreg[0]}, {tbl[i].ea, tbl[i].er});
            n = 0;
            while (busy[0] && n < 20) begin
                tick;
                n++;
            end
            chk("vec_gap", n, 4);
        end
        chk("vec_fault", fault[0], 0);

        // both requesters held: rr alternates, fixed priority starves port 1
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;
        valid = 2'b11;
        a0 = 8'h11; d0 = 8'h01; a1 = 8'h3A; d1 = 8'h04;
        g_cnt = 0; last_done = 0; fp0 = 0; fp1 = 0; seq = '0; n = 0;
        while (g_cnt < 4 && n < 400) begin
            tick;
            n++;
            if (done0[0] | done1[0]) last_done = n;
            if (rdy0[0] | rdy1[0]) begin
                seq[g_cnt] = rdy1[0];
                if (g_cnt > 0) chk("rr_gap", n - last_done, 5);
                g_cnt++;
            end
            fp0 += int'(rdy0[1]);
            fp1 += int'(rdy1[1]);
        end
        chk("rr_count", g_cnt, 4);
        chk("rr_order", seq, 4'b1010);
        chk("fp_port0", fp0, 4);
        chk("fp_port1", fp1, 0);
        valid = 2'b00;
        wait_idle;

        // hung master: ready never drops after start
        rst = 1'b1;
        tick;
        rst = 1'b0;
        mode = M_HUNG;
        tick;
        valid = 2'b01;
        a0 = 8'h12; d0 = 8'h80;
        tick;
        chk("hung_ready", rdy0[0], 1);
        valid = 2'b00;
        n = 0;
        while (start[0] && n < 200) begin
            tick;
            n++;
        end
        chk("hung_start_drop", n, 50);
        chk("hung_done", {done0[0], err0[0]}, 2'b11);
        chk("hung_fault", fault[0], 1);
        mode = M_NORM;
        wait_idle;
        valid = 2'b10;
        a1 = 8'h3A; d1 = 8'h04;
        tick;
        chk("post_hung_ready", rdy1[0], 1);
        valid = 2'b00;
        n = 0;
        while (!done1[0] && n < 100) begin
            tick;
            n++;
        end
        chk("post_hung_done", {done1[0], err1[0]}, 2'b10);
        chk("fault_sticky", fault[0], 1);
        wait_idle;

        // master accepts but never finishes
        mode = M_STUCK;
        valid = 2'b10;
        a1 = 8'h3A; d1 = 8'h04;
        tick;
        chk("stuck_ready", rdy1[0], 1);
        valid = 2'b00;
        n = 0;
        while (start[0] && n < 100) begin
            tick;
            n++;
        end
        chk("stuck_ack_lat", n, 3);
        n = 0;
        while (!done1[0] && n < 200) begin
            tick;
            n++;
        end
        chk("stuck_to_lat", n, 50);
        chk("stuck_err", err1[0], 1);
        chk("stuck_fault", fault[0], 1);
        mode = M_NORM;
        wait_idle;

        // async reset in WAIT_DONE, then normal service from port 0
        valid = 2'b01;
        a0 = 8'h12; d0 = 8'h80;
        tick;
        chk("mid_ready", rdy0[0], 1);
        valid = 2'b00;
        n = 0;
        while (start[0] && n < 100) begin
            tick;
            n++;
        end
        repeat (5) tick;
        chk("mid_pre", {busy[0], fault[0]}, 2'b11);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst", {start[0], busy[0], done0[0], done1[0], fault[0]}, 0);
        tick;
        rst = 1'b0;
        tick;
        valid = 2'b01;
        a0 = 8'h21; d0 = 8'h43;
        tick;
        chk("after_rst_ready", {rdy1[0], rdy0[0], gid[0]}, 3'b010);
        chk("after_rst_addr", {saddr[0], sreg[0]}, 16'h2143);
        valid = 2'b00;
        n = 0;
        while (!done0[0] && n < 100) begin
            tick;
            n++;
        end
        chk("after_rst_done", {done0[0], err0[0], fault[0]}, 3'b100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
